// File: rtl/muldiv_iter_unit.sv
// Iterative RV M-extension execute unit (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
// Works on operand magnitudes BITS_PER_CYCLE bits per clock, then spends one
// cycle restoring signs and selecting the result half. Abortable via kill_i.
module muldiv_iter_unit #(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            kill_i,
  output logic            ready_o,
  output logic            busy_o,
  output logic            valid_o,
  output logic [XLEN-1:0] result_o
);

  localparam int K     = XLEN / BITS_PER_CYCLE;
  localparam int CNT_W = $clog2(K);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_e;

  state_e              state_q, state_d;
  logic [2:0]          op_q, op_d;
  logic                sa_q, sa_d;      // effective sign of a
  logic                sb_q, sb_d;      // effective sign of b
  logic                spec_q, spec_d;  // special case: p_q low half holds the answer
  logic [XLEN-1:0]     m_q, m_d;        // multiplicand (mul) or divisor (div) magnitude
  logic [2*XLEN-1:0]   p_q, p_d;        // mul: {acc_hi, multiplier}; div: {remainder, dividend/quotient}
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [XLEN-1:0]     result_q, result_d;

  logic                signed_a, signed_b, neg_a, neg_b;
  logic [XLEN-1:0]     a_mag, b_mag, spec_val;
  logic                div_zero, div_ovf;
  logic [2*XLEN-1:0]   p_step;
  logic [XLEN:0]       rr, sum;
  logic                qbit;
  logic [2*XLEN-1:0]   prod_fix;
  logic [XLEN-1:0]     quo_fix, rem_fix, fix_res;

  // Decode signedness from funct3 and detect the divide special cases.
  always_comb begin
    signed_a = op_i[2] ? ~op_i[0] : (op_i[1:0] != 2'b11);
    signed_b = op_i[2] ? ~op_i[0] : ~op_i[1];
    neg_a    = signed_a & a_i[XLEN-1];
    neg_b    = signed_b & b_i[XLEN-1];
    a_mag    = neg_a ? -a_i : a_i;
    b_mag    = neg_b ? -b_i : b_i;
    div_zero = op_i[2] & (b_i == '0);
    div_ovf  = op_i[2] & ~op_i[0] & (a_i == {1'b1, {(XLEN-1){1'b0}}}) & (b_i == '1);
    spec_val = '0;
    if (div_zero)     spec_val = op_i[1] ? a_i : '1;
    else if (div_ovf) spec_val = op_i[1] ? '0 : a_i;
  end

  // Unrolled BITS_PER_CYCLE shift-add or restoring compare/subtract stages.
  // NOTE: blocking assignments here chain each unrolled stage into the next
  // within one cycle; state registers below only ever use non-blocking.
  always_comb begin
    p_step = p_q;
    rr     = '0;
    sum    = '0;
    qbit   = 1'b0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (op_q[2]) begin
        rr   = {p_step[2*XLEN-1:XLEN], p_step[XLEN-1]};
        qbit = (rr >= {1'b0, m_q});
        if (qbit) rr = rr - {1'b0, m_q};
        p_step = {rr[XLEN-1:0], p_step[XLEN-2:0], qbit};
      end else begin
        sum    = {1'b0, p_step[2*XLEN-1:XLEN]} + (p_step[0] ? {1'b0, m_q} : {(XLEN+1){1'b0}});
        p_step = {sum, p_step[XLEN-1:1]};
      end
    end
  end

  // Sign restoration and result selection used in the FIX cycle.
  always_comb begin
    prod_fix = (sa_q ^ sb_q) ? -p_q : p_q;
    quo_fix  = (sa_q ^ sb_q) ? -p_q[XLEN-1:0] : p_q[XLEN-1:0];
    rem_fix  = sa_q ? -p_q[2*XLEN-1:XLEN] : p_q[2*XLEN-1:XLEN];
    if (spec_q)                 fix_res = p_q[XLEN-1:0];
    else if (!op_q[2])          fix_res = (op_q[1:0] == 2'b00) ? prod_fix[XLEN-1:0]
                                                               : prod_fix[2*XLEN-1:XLEN];
    else if (op_q[1])           fix_res = rem_fix;
    else                        fix_res = quo_fix;
  end

  // Next-state and datapath update; kill_i overrides everything.
  // NOTE: every target gets its hold value first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    spec_d   = spec_q;
    m_d      = m_q;
    p_d      = p_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    if (kill_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (start_i) begin
          op_d   = op_i;
          sa_d   = neg_a;
          sb_d   = neg_b;
          spec_d = div_zero | div_ovf;
          cnt_d  = CNT_W'(K - 1);
          if (div_zero | div_ovf) begin
            p_d     = {{XLEN{1'b0}}, spec_val};
            state_d = S_FIX;
          end else begin
            m_d     = op_i[2] ? b_mag : a_mag;
            p_d     = {{XLEN{1'b0}}, op_i[2] ? a_mag : b_mag};
            state_d = S_CALC;
          end
        end
        S_CALC: begin
          p_d   = p_step;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == '0) state_d = S_FIX;
        end
        S_FIX: begin
          result_d = fix_res;
          state_d  = S_DONE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and datapath registers, cleared by the asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      spec_q   <= 1'b0;
      m_q      <= '0;
      p_q      <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      spec_q   <= spec_d;
      m_q      <= m_d;
      p_q      <= p_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  assign ready_o  = (state_q == S_IDLE);
  assign busy_o   = ~ready_o;
  assign valid_o  = (state_q == S_DONE) & ~kill_i;
  assign result_o = result_q;

endmodule

// File: tb/tb_muldiv_iter_unit.sv
// Directed bench for muldiv_iter_unit: three instances (32/1, 32/4, 16/4)
// checked against hand-computed results and cycle latencies.
module tb_muldiv_iter_unit;

  localparam logic [2:0] OP_MUL = 3'b000, OP_MULH = 3'b001, OP_MULHSU = 3'b010, OP_MULHU = 3'b011;
  localparam logic [2:0] OP_DIV = 3'b100, OP_DIVU = 3'b101, OP_REM = 3'b110, OP_REMU = 3'b111;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  start_v = '0;
  logic [2:0]  op = '0;
  logic [31:0] a = '0, b = '0;
  logic        kill = 1'b0;

  logic        rdy0, bsy0, vld0, rdy4, bsy4, vld4, rdy16, bsy16, vld16;
  logic [31:0] res0, res4;
  logic [15:0] res16;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  muldiv_iter_unit #(.XLEN(32), .BITS_PER_CYCLE(1)) dut (
    .clk_i(clk), .reset_i(rst_n), .start_i(start_v[0]), .op_i(op), .a_i(a), .b_i(b),
    .kill_i(kill), .ready_o(rdy0), .busy_o(bsy0), .valid_o(vld0), .result_o(res0));

  muldiv_iter_unit #(.XLEN(32), .BITS_PER_CYCLE(4)) dut4 (
    .clk_i(clk), .reset_i(rst_n), .start_i(start_v[1]), .op_i(op), .a_i(a), .b_i(b),
    .kill_i(kill), .ready_o(rdy4), .busy_o(bsy4), .valid_o(vld4), .result_o(res4));

  muldiv_iter_unit #(.XLEN(16), .BITS_PER_CYCLE(4)) dut16 (
    .clk_i(clk), .reset_i(rst_n), .start_i(start_v[2]), .op_i(op), .a_i(a[15:0]), .b_i(b[15:0]),
    .kill_i(kill), .ready_o(rdy16), .busy_o(bsy16), .valid_o(vld16), .result_o(res16));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic get_ready(input int s);
    case (s)
      0: get_ready = rdy0;
      1: get_ready = rdy4;
      default: get_ready = rdy16;
    endcase
  endfunction

  function automatic logic get_valid(input int s);
    case (s)
      0: get_valid = vld0;
      1: get_valid = vld4;
      default: get_valid = vld16;
    endcase
  endfunction

  function automatic logic [31:0] get_result(input int s);
    case (s)
      0: get_result = res0;
      1: get_result = res4;
      default: get_result = {16'h0, res16};
    endcase
  endfunction

  // Issue one op on instance s, scramble operands after acceptance, poke a
  // start that must be ignored, then check latency, result and pulse width.
  task automatic run_op(input int s, input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv,
                        input logic [31:0] exp, input int lat, input string tag);
    int n;
    int guard;
    guard = 0;
    @(negedge clk);
    while (!get_ready(s) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check({tag, " ready"}, get_ready(s), 1'b1);
    op = o; a = av; b = bv;
    start_v[s] = 1'b1;
    @(posedge clk); #1;
    start_v[s] = 1'b0;
    a = $urandom; b = $urandom; op = 3'($urandom);
    n = 1;
    while (!get_valid(s) && n < 200) begin
      @(posedge clk); #1;
      n++;
      start_v[s] = (n == 3);
    end
    start_v[s] = 1'b0;
    check({tag, " latency"}, n, lat);
    check({tag, " result"}, get_result(s), exp);
    @(posedge clk); #1;
    check({tag, " pulse"}, get_valid(s), 1'b0);
  endtask

  initial begin
    int n;
    int bad;

    // Reset values
    #1;
    check("rst ready", rdy0, 1'b1);
    check("rst busy", bsy0, 1'b0);
    check("rst valid", vld0, 1'b0);
    check("rst result", res0, 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Main function, XLEN=32, one bit per cycle
    run_op(0, OP_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 34, "mul");
    run_op(0, OP_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 34, "mulh");
    run_op(0, OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 34, "mulhsu");
    run_op(0, OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34, "mulhu");
    run_op(0, OP_MULHU,  32'h00010000, 32'h00010000, 32'h00000001, 34, "mulhu2^32");
    run_op(0, OP_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34, "div");
    run_op(0, OP_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34, "rem");
    run_op(0, OP_DIV,    32'd20,       32'hFFFFFFFD, 32'hFFFFFFFA, 34, "div_negb");
    run_op(0, OP_REM,    32'd20,       32'hFFFFFFFD, 32'd2,        34, "rem_negb");
    run_op(0, OP_DIVU,   32'd100,      32'd7,        32'd14,       34, "divu");
    run_op(0, OP_REMU,   32'd100,      32'd7,        32'd2,        34, "remu");
    run_op(0, OP_REMU,   32'hFFFFFFFF, 32'h10,       32'hF,        34, "remu_big");
    // Specials
    run_op(0, OP_DIV,    32'd5,        32'd0,        32'hFFFFFFFF, 2, "div0");
    run_op(0, OP_REMU,   32'd5,        32'd0,        32'd5,        2, "remu0");
    run_op(0, OP_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 2, "div_ovf");
    run_op(0, OP_REM,    32'h80000000, 32'hFFFFFFFF, 32'h0,        2, "rem_ovf");

    // Kill at cycle 10 of a DIV: last result was 0 (rem_ovf)
    @(negedge clk);
    op = OP_DIV; a = 32'd100; b = 32'd7; start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    n = 1;
    bad = 0;
    while (n < 10) begin
      @(posedge clk); #1;
      n++;
      if (vld0) bad++;
    end
    kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    check("kill ready", rdy0, 1'b1);
    check("kill result", res0, 32'h0);
    repeat (40) begin
      @(posedge clk); #1;
      if (vld0) bad++;
    end
    check("kill no valid", bad, 0);
    run_op(0, OP_DIVU, 32'd100, 32'd7, 32'd14, 34, "after kill");

    // Kill during FIX of a special op: no valid, result held at 14
    @(negedge clk);
    op = OP_DIV; a = 32'd5; b = 32'd0; start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    check("killfix valid", vld0, 1'b0);
    check("killfix ready", rdy0, 1'b1);
    check("killfix result", res0, 32'd14);

    // Kill beats start in IDLE
    @(negedge clk);
    op = OP_MUL; a = 32'd3; b = 32'd3; start_v[0] = 1'b1; kill = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0; kill = 1'b0;
    check("killstart ready", rdy0, 1'b1);
    bad = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (vld0) bad++;
    end
    check("killstart no valid", bad, 0);
    check("killstart result", res0, 32'd14);

    // Four bits per cycle (latency 10) and XLEN=16 (latency 6)
    run_op(1, OP_MUL,  32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 10, "b4 mul");
    run_op(1, OP_DIV,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 10, "b4 div");
    run_op(1, OP_REMU, 32'd100,      32'd7,        32'd2,        10, "b4 remu");
    run_op(2, OP_MULH, 32'h8000,     32'h8000,     32'h4000,     6,  "x16 mulh");
    run_op(2, OP_DIV,  32'hFFF9,     32'h0002,     32'hFFFD,     6,  "x16 div");

    // Reset mid-operation
    @(negedge clk);
    op = OP_MUL; a = 32'd9; b = 32'd9; start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst ready", rdy0, 1'b1);
    check("midrst valid", vld0, 1'b0);
    check("midrst result", res0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(0, OP_MUL, 32'd9, 32'd9, 32'd81, 34, "after reset");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
